uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and byte sequencer that shares one UART transmitter (the `uart_fsm_1` engine driven at baud rate by `clock_divider`) among `N_REQ` independent byte-stream requesters. Each requester is granted for one packet, up to `MAX_BURST` bytes. The arbiter hands bytes to the UART one at a time with a start/busy handshake, acknowledges each byte back to its owner, and rotates priority after every grant. It replaces the single-source `transmitter` controller when several producers share the TX line.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 16: maximum bytes per grant before forced rotation, 1..255.
- `system_clock` input 1: single clock for all logic.
- `rst` input 1: synchronous, active-high reset.
- `req` input N_REQ: requester i has a byte pending on its data lane.
- `req_data` input 8*N_REQ: lane i is bits [8i+7:8i], held stable while `req[i]` is high.
- `req_last` input N_REQ: the pending byte of requester i ends its packet.
- `req_ack` output N_REQ: one-cycle pulse; the UART has taken lane i's byte, so the requester advances.
- `grant` output N_REQ: one-hot owner of the UART, all zero when idle.
- `uart_start` output 1: start request to the UART (`center_push`).
- `uart_data` output 8: byte to the UART, registered.
- `uart_busy` input 1: UART `tx_busy`.
- `pkt_done` output 1: one-cycle pulse when a grant ends.
- `bytes_sent` output 16: total bytes accepted by the UART, wraps at 65535→0.

## Operation
- States: IDLE, LOAD, WAIT_HI, WAIT_LO, RELEASE.
- **IDLE**:
  - If `req` is nonzero, select the first requester at or after `rr_ptr`, searching upward modulo N_REQ.
  - Register `grant` for the selected requester, clear `burst_cnt`, and go to LOAD.
  - If `req` is zero, stay in IDLE.
- **LOAD**:
  - If `req[g]` is low (the requester withdrew), go to RELEASE without sending.
  - Otherwise latch `uart_data` from lane g, latch `last_q` from `req_last[g]`, drive `uart_start` high, and go to WAIT_HI.
- **WAIT_HI**:
  - Hold `uart_start` high until `uart_busy` is sampled high. This is needed because the UART only samples start on a `clock_enable` tick.
  - On that cycle: drop `uart_start`, pulse `req_ack[g]`, increment `bytes_sent` and `burst_cnt`, and go to WAIT_LO.
- **WAIT_LO**: wait for `uart_busy` low.
  - Then, if `last_q` is set or `burst_cnt == MAX_BURST`, go to RELEASE.
  - Otherwise go to LOAD, keeping the same grant.
- **RELEASE**:
  - Set `rr_ptr = (g+1) mod N_REQ`, clear `grant`, pulse `pkt_done`, and go to IDLE.
- A grant is never preempted mid-packet except by the `MAX_BURST` limit. A truncated packet resumes under a later grant, with no bytes lost or repeated.
- Requests from other lanes during a grant are ignored until IDLE.

## Timing
- Reset, on the first `system_clock` edge with `rst` high:
  - State goes to IDLE and `rr_ptr` to 0.
  - `grant`, `req_ack`, `uart_start`, `uart_data`, `pkt_done`, `bytes_sent` and `burst_cnt` all go to 0.
  - Reset mid-transfer drops `uart_start` immediately. The byte already inside the UART is not tracked.
- From `req` rising in IDLE: `grant` is visible 1 cycle later, and `uart_start` is high 2 cycles later.
- `req_ack[g]` is asserted in exactly one cycle per byte, the same cycle `uart_start` falls.
- Between consecutive bytes of a packet there is 1 cycle (LOAD) after `uart_busy` falls before the next `uart_start`.
- There is a minimum of 2 idle cycles (RELEASE, IDLE) between packets of different requesters.
- `uart_busy` already high on entry to LOAD: the arbiter still asserts start and accepts only after a fresh rising edge of `uart_busy`.
  - Implement this with a registered `uart_busy` edge detect.
  - Consequence: WAIT_HI accepts only on a 0→1 transition of `uart_busy`.
- `pkt_done` and the `rr_ptr` update occur in the RELEASE cycle.
- `bytes_sent` wraps at 0xFFFF+1 to 0 with no flag.

## Test plan
- **Single requester, 3-byte packet**: req[1]=1 with bytes 0x41, 0x42, 0x43 (last on 0x43).
  - `uart_data` shows 0x41, 0x42, 0x43 in order.
  - Three `req_ack[1]` pulses, one `pkt_done`, `bytes_sent`=3, `grant` back to 0.
- **Round-robin among all requesters**: all `req` high, each with 1-byte packets, starting after reset.
  - Grant order is 0, 1, 2, 3, 0.
  - With req[0] and req[2] only after servicing 0: the next grant is 2, then 0.
- **Burst limit**: MAX_BURST=4, req[0] sends a 6-byte packet while req[3] is pending.
  - 4 bytes from lane 0, then `pkt_done`, then req[3]'s packet.
  - Then the remaining 2 bytes from lane 0.
  - `bytes_sent` matches the total byte count.
- **Handshake latency**: model the UART raising busy 5 cycles after start.
  - `uart_start` stays high for exactly 5 cycles.
  - `req_ack` pulses once, in the cycle busy is first sampled high.
- **Reset during transfer**: assert `rst` in WAIT_LO.
  - The next cycle has all outputs 0 and state IDLE.
  - The next request is granted starting from requester 0.
- **Withdrawal**: drop req[2] while in LOAD.
  - No `uart_start` and no `req_ack`.
  - `pkt_done` pulses and `rr_ptr` becomes 3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter that sequences packets from N_REQ byte-stream
//            requesters into one shared UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic               system_clock,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   grant,
    output logic               uart_start,
    output logic [7:0]         uart_data,
    input  logic               uart_busy,
    output logic               pkt_done,
    output logic [15:0]        bytes_sent
);

    localparam int         C_IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [N_REQ-1:0]     r_grant;
    logic [C_IDX_W-1:0]   r_g_idx;
    logic [C_IDX_W-1:0]   r_rr_ptr;
    logic [7:0]           r_burst_cnt;
    logic                 r_last_q;
    logic [7:0]           r_uart_data;
    logic                 r_uart_start;
    logic [N_REQ-1:0]     r_req_ack;
    logic [15:0]          r_bytes_sent;
    logic                 r_busy_q;

    logic                 w_busy_rise;
    logic                 w_sel_found;
    logic [C_IDX_W-1:0]   w_sel_idx;
    logic [N_REQ-1:0]     w_sel_onehot;
    logic                 w_lane_req;
    logic                 w_lane_last;
    logic [7:0]           w_lane_data;
    logic                 w_do_grant;
    logic                 w_do_load;
    logic                 w_do_accept;
    logic                 w_do_release;

    function automatic logic [C_IDX_W-1:0] f_wrap(input int v);
        int w_wrapped;
        w_wrapped = (v >= N_REQ) ? (v - N_REQ) : v;
        return C_IDX_W'(w_wrapped);
    endfunction

    // Start is only honoured on a fresh 0->1 of busy, so a UART still busy
    // from an earlier byte cannot be mistaken for acceptance.
    assign w_busy_rise = uart_busy & ~r_busy_q;

    // Descending scan so the candidate closest to rr_ptr wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[f_wrap(int'(r_rr_ptr) + k)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = f_wrap(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_sel_onehot = N_REQ'(1) << w_sel_idx;

    always_comb begin
        w_lane_req  = 1'b0;
        w_lane_last = 1'b0;
        w_lane_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_g_idx == C_IDX_W'(i)) begin
                w_lane_req  = req[i];
                w_lane_last = req_last[i];
                w_lane_data = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge system_clock) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_do_grant   = 1'b0;
        w_do_load    = 1'b0;
        w_do_accept  = 1'b0;
        w_do_release = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_do_grant   = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!w_lane_req) begin
                    w_state_next = S_RELEASE;
                end else begin
                    w_do_load    = 1'b1;
                    w_state_next = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (w_busy_rise) begin
                    w_do_accept  = 1'b1;
                    w_state_next = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!uart_busy) begin
                    if (r_last_q || (r_burst_cnt == C_MAX_BURST)) begin
                        w_state_next = S_RELEASE;
                    end else begin
                        w_state_next = S_LOAD;
                    end
                end
            end
            S_RELEASE: begin
                w_do_release = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (rst) begin
            r_grant      <= '0;
            r_g_idx      <= '0;
            r_rr_ptr     <= '0;
            r_burst_cnt  <= 8'h00;
            r_last_q     <= 1'b0;
            r_uart_data  <= 8'h00;
            r_uart_start <= 1'b0;
            r_req_ack    <= '0;
            r_bytes_sent <= 16'h0000;
            r_busy_q     <= 1'b0;
        end else begin
            r_busy_q  <= uart_busy;
            r_req_ack <= '0;
            if (w_do_grant) begin
                r_grant     <= w_sel_onehot;
                r_g_idx     <= w_sel_idx;
                r_burst_cnt <= 8'h00;
            end
            if (w_do_load) begin
                r_uart_data  <= w_lane_data;
                r_last_q     <= w_lane_last;
                r_uart_start <= 1'b1;
            end
            if (w_do_accept) begin
                r_uart_start <= 1'b0;
                r_req_ack    <= r_grant;
                r_bytes_sent <= r_bytes_sent + 16'd1;
                r_burst_cnt  <= r_burst_cnt + 8'd1;
            end
            if (w_do_release) begin
                r_rr_ptr <= f_wrap(int'(r_g_idx) + 1);
                r_grant  <= '0;
            end
        end
    end

    assign grant      = r_grant;
    assign req_ack    = r_req_ack;
    assign uart_start = r_uart_start;
    assign uart_data  = r_uart_data;
    assign bytes_sent = r_bytes_sent;
    assign pkt_done   = (r_state == S_RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter with lane FIFOs
//            and a UART busy-handshake model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ack;
    logic [N-1:0]  grant;
    logic          uart_start;
    logic [7:0]    uart_data;
    logic          uart_busy;
    logic          pkt_done;
    logic [15:0]   bytes_sent;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
        .system_clock (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ack      (req_ack),
        .grant        (grant),
        .uart_start   (uart_start),
        .uart_data    (uart_data),
        .uart_busy    (uart_busy),
        .pkt_done     (pkt_done),
        .bytes_sent   (bytes_sent)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   lane_buf [N][16];
    logic         lane_lst [N][16];
    int           lane_wr [N];
    int           lane_rd [N];
    logic [N-1:0] blk = '0;
    bit           withdraw_arm = 1'b0;
    int           busy_delay = 1;
    int           busy_len   = 3;
    int           st_cnt = 0;
    int           hold   = 0;

    int           cyc = 0;
    int           log_n = 0;
    int           done_n = 0;
    int           g_n = 0;
    int           ack_bad = 0;
    int           last_done_cyc = 0;
    int           log_lane [64];
    logic [7:0]   log_byte [64];
    logic [N-1:0] glog [16];
    int           gap [16];
    logic [N-1:0] prev_grant = '0;

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Requester lanes and UART busy model, updated just after each rising edge.
    initial begin
        req = '0; req_data = '0; req_last = '0; uart_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (req_ack[i] && lane_rd[i] < lane_wr[i]) lane_rd[i]++;
            if (withdraw_arm && grant[2]) begin
                blk[2] = 1'b1;
                withdraw_arm = 1'b0;
            end
            if (uart_busy) begin
                hold--;
                if (hold <= 0) uart_busy = 1'b0;
            end else if (uart_start) begin
                st_cnt++;
                if (st_cnt >= busy_delay) begin
                    uart_busy = 1'b1;
                    hold = busy_len;
                    st_cnt = 0;
                end
            end else begin
                st_cnt = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (!blk[i] && lane_rd[i] < lane_wr[i]) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = lane_buf[i][lane_rd[i]];
                    req_last[i] = lane_lst[i][lane_rd[i]];
                end else begin
                    req[i] = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    // Event recorder sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (req_ack != '0) begin
                if (log_n < 64) begin
                    log_lane[log_n] = oh2idx(req_ack);
                    log_byte[log_n] = uart_data;
                end
                log_n++;
                if (req_ack !== grant) ack_bad++;
            end
            if (pkt_done) begin
                done_n++;
                last_done_cyc = cyc;
            end
            if (grant != '0 && prev_grant == '0) begin
                if (g_n < 16) begin
                    glog[g_n] = grant;
                    gap[g_n]  = cyc - last_done_cyc;
                end
                g_n++;
            end
            prev_grant = grant;
        end
    end

    task automatic push(input int lane, input logic [7:0] b, input logic l);
        lane_buf[lane][lane_wr[lane]] = b;
        lane_lst[lane][lane_wr[lane]] = l;
        lane_wr[lane]++;
    endtask

    task automatic clear_log();
        @(posedge clk);
        log_n = 0; done_n = 0; g_n = 0; ack_bad = 0;
        for (int i = 0; i < 64; i++) begin log_lane[i] = -1; log_byte[i] = 8'h00; end
        for (int i = 0; i < 16; i++) begin glog[i] = '0; gap[i] = 0; end
        for (int i = 0; i < N; i++) begin lane_wr[i] = 0; lane_rd[i] = 0; end
        @(negedge clk);
    endtask

    task automatic wait_quiet(input string name);
        int q = 0;
        int t = 0;
        while (q < 4 && t < 600) begin
            @(negedge clk);
            t++;
            if (req == '0 && grant == '0) q++; else q = 0;
        end
        n_checks++;
        if (q < 4) begin n_fail++; $display("FAIL %s_idle: not idle after %0d cycles, required idle", name, t); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b required 0000", grant); end
        n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b required 0000", req_ack); end
        n_checks++; if (uart_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b required 0", uart_start); end
        n_checks++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h required 00", uart_data); end
        n_checks++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", pkt_done); end
        n_checks++; if (bytes_sent !== 16'h0000) begin n_fail++; $display("FAIL rst_count: got %0d required 0", bytes_sent); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
        clear_log();
        push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
        @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_early: got %b required 0000", grant); end
        @(negedge clk);
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant_lat: got %b required 0010", grant); end
        n_checks++; if (uart_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b required 0", uart_start); end
        @(negedge clk);
        n_checks++; if (uart_start !== 1'b1) begin n_fail++; $display("FAIL single_start_lat: got %b required 1", uart_start); end
        n_checks++; if (uart_data !== 8'h41) begin n_fail++; $display("FAIL single_data_first: got %h required 41", uart_data); end
        wait_quiet("single");
        n_checks++; if (log_n !== 3) begin n_fail++; $display("FAIL single_acks: got %0d required 3", log_n); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (log_lane[k] !== 1 || log_byte[k] !== exp_b[k]) begin
                n_fail++; $display("FAIL single_byte%0d: got lane %0d byte %h required lane 1 byte %h", k, log_lane[k], log_byte[k], exp_b[k]);
            end
        end
        n_checks++; if (done_n !== 1) begin n_fail++; $display("FAIL single_pkt_done: got %0d required 1", done_n); end
        n_checks++; if (bytes_sent !== 16'd3) begin n_fail++; $display("FAIL single_count: got %0d required 3", bytes_sent); end
        n_checks++; if (ack_bad !== 0) begin n_fail++; $display("FAIL single_ack_owner: got %0d stray acks required 0", ack_bad); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0]   exp_b [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        int           exp_l [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1); push(0, 8'hA4, 1'b1);
        wait_quiet("rr");
        n_checks++; if (g_n !== 5) begin n_fail++; $display("FAIL rr_grants: got %0d required 5", g_n); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (glog[k] !== exp_g[k]) begin n_fail++; $display("FAIL rr_order%0d: got %b required %b", k, glog[k], exp_g[k]); end
            n_checks++;
            if (log_lane[k] !== exp_l[k] || log_byte[k] !== exp_b[k]) begin
                n_fail++; $display("FAIL rr_byte%0d: got lane %0d byte %h required lane %0d byte %h", k, log_lane[k], log_byte[k], exp_l[k], exp_b[k]);
            end
        end
        for (int k = 1; k < 5; k++) begin
            n_checks++;
            if (gap[k] !== 2) begin n_fail++; $display("FAIL rr_gap%0d: got %0d cycles required 2", k, gap[k]); end
        end
        n_checks++; if (done_n !== 5) begin n_fail++; $display("FAIL rr_pkt_done: got %0d required 5", done_n); end
        n_checks++; if (bytes_sent !== 16'd5) begin n_fail++; $display("FAIL rr_count: got %0d required 5", bytes_sent); end
        clear_log();
        push(0, 8'hB0, 1'b1); push(2, 8'hB2, 1'b1);
        wait_quiet("rr2");
        n_checks++; if (glog[0] !== 4'b0100) begin n_fail++; $display("FAIL rr2_first: got %b required 0100", glog[0]); end
        n_checks++; if (glog[1] !== 4'b0001) begin n_fail++; $display("FAIL rr2_second: got %b required 0001", glog[1]); end
        n_checks++; if (bytes_sent !== 16'd7) begin n_fail++; $display("FAIL rr2_count: got %0d required 7", bytes_sent); end
    endtask

    task automatic test_burst();
        int         t = 0;
        logic [7:0] exp_b [8] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hC4, 8'hC5};
        int         exp_l [8] = '{0, 0, 0, 0, 3, 3, 0, 0};
        clear_log();
        for (int k = 0; k < 6; k++) push(0, 8'hC0 + 8'(k), (k == 5));
        while (grant !== 4'b0001 && t < 50) begin @(negedge clk); t++; end
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL burst_grant0: got %b required 0001", grant); end
        push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b1);
        wait_quiet("burst");
        n_checks++; if (log_n !== 8) begin n_fail++; $display("FAIL burst_acks: got %0d required 8", log_n); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (log_lane[k] !== exp_l[k] || log_byte[k] !== exp_b[k]) begin
                n_fail++; $display("FAIL burst_byte%0d: got lane %0d byte %h required lane %0d byte %h", k, log_lane[k], log_byte[k], exp_l[k], exp_b[k]);
            end
        end
        n_checks++; if (glog[1] !== 4'b1000) begin n_fail++; $display("FAIL burst_rotate: got %b required 1000", glog[1]); end
        n_checks++; if (glog[2] !== 4'b0001) begin n_fail++; $display("FAIL burst_resume: got %b required 0001", glog[2]); end
        n_checks++; if (done_n !== 3) begin n_fail++; $display("FAIL burst_pkt_done: got %0d required 3", done_n); end
        n_checks++; if (bytes_sent !== 16'd15) begin n_fail++; $display("FAIL burst_count: got %0d required 15", bytes_sent); end
    endtask

    task automatic test_withdrawal();
        int  t = 0;
        int  starts = 0;
        int  acks = 0;
        bit  done = 1'b0;
        clear_log();
        withdraw_arm = 1'b1;
        push(2, 8'hF2, 1'b1);
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
            if (uart_start) starts++;
            if (req_ack != '0) acks++;
            if (pkt_done) done = 1'b1;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wd_pkt_done: got %b required 1", done); end
        n_checks++; if (starts !== 0) begin n_fail++; $display("FAIL wd_start: got %0d cycles required 0", starts); end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL wd_ack: got %0d required 0", acks); end
        lane_rd[2] = lane_wr[2];
        blk[2] = 1'b0;
        push(0, 8'h50, 1'b1); push(1, 8'h51, 1'b1);
        wait_quiet("wd");
        n_checks++; if (glog[0] !== 4'b0100) begin n_fail++; $display("FAIL wd_grant: got %b required 0100", glog[0]); end
        n_checks++; if (glog[1] !== 4'b0001) begin n_fail++; $display("FAIL wd_next: got %b required 0001", glog[1]); end
        n_checks++; if (glog[2] !== 4'b0010) begin n_fail++; $display("FAIL wd_after: got %b required 0010", glog[2]); end
        n_checks++; if (bytes_sent !== 16'd17) begin n_fail++; $display("FAIL wd_count: got %0d required 17", bytes_sent); end
    endtask

    task automatic test_handshake();
        int           t = 0;
        int           hi = 0;
        int           acks = 0;
        bit           fell = 1'b0;
        bit           done = 1'b0;
        logic [N-1:0] ack_fall = '0;
        clear_log();
        busy_delay = 5;
        push(2, 8'h5E, 1'b1);
        while (!done && t < 80) begin
            @(negedge clk);
            t++;
            if (uart_start) hi++;
            if (hi > 0 && !uart_start && !fell) begin fell = 1'b1; ack_fall = req_ack; end
            if (req_ack != '0) acks++;
            if (pkt_done) done = 1'b1;
        end
        busy_delay = 1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hs_done: got %b required 1", done); end
        n_checks++; if (hi !== 5) begin n_fail++; $display("FAIL hs_start_len: got %0d cycles required 5", hi); end
        n_checks++; if (ack_fall !== 4'b0100) begin n_fail++; $display("FAIL hs_ack_at_fall: got %b required 0100", ack_fall); end
        n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL hs_ack_count: got %0d required 1", acks); end
        wait_quiet("hs");
        n_checks++; if (bytes_sent !== 16'd18) begin n_fail++; $display("FAIL hs_count: got %0d required 18", bytes_sent); end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clear_log();
        push(1, 8'h60, 1'b0); push(1, 8'h61, 1'b1);
        while (req_ack == '0 && t < 60) begin @(negedge clk); t++; end
        n_checks++; if (req_ack !== 4'b0010) begin n_fail++; $display("FAIL rm_ack: got %b required 0010", req_ack); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rm_grant: got %b required 0000", grant); end
        n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL rm_ack_clr: got %b required 0000", req_ack); end
        n_checks++; if (uart_start !== 1'b0) begin n_fail++; $display("FAIL rm_start: got %b required 0", uart_start); end
        n_checks++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL rm_data: got %h required 00", uart_data); end
        n_checks++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL rm_done: got %b required 0", pkt_done); end
        n_checks++; if (bytes_sent !== 16'h0000) begin n_fail++; $display("FAIL rm_count: got %0d required 0", bytes_sent); end
        lane_rd[1] = lane_wr[1];
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        push(3, 8'h73, 1'b1); push(0, 8'h70, 1'b1);
        wait_quiet("rm");
        n_checks++; if (glog[0] !== 4'b0001) begin n_fail++; $display("FAIL rm_first: got %b required 0001", glog[0]); end
        n_checks++; if (glog[1] !== 4'b1000) begin n_fail++; $display("FAIL rm_second: got %b required 1000", glog[1]); end
        n_checks++; if (log_byte[0] !== 8'h70 || log_byte[1] !== 8'h73) begin
            n_fail++; $display("FAIL rm_bytes: got %h %h required 70 73", log_byte[0], log_byte[1]);
        end
        n_checks++; if (bytes_sent !== 16'd2) begin n_fail++; $display("FAIL rm_total: got %0d required 2", bytes_sent); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_withdrawal();
        test_handshake();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
